// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell plus a registered carry, LSB first.
// Result and carry-out are held until the next done pulse.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             accept;

    full_adder u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c_in  (carry),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    assign busy   = (state == RUN);
    assign ready  = ~busy;
    assign done   = (state == DONE);
    assign accept = start & ready;

    // New bit enters at the MSB; the shift form also covers WIDTH=1 cleanly.
    assign s_next = WIDTH'({fa_sum, s_sh} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            cnt   <= '0;
            s_sh  <= '0;
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_next;
                    carry <= fa_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= s_next;
                        c_out <= fa_cout;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 main instance plus a WIDTH=1 instance.
// Expected results are queued at start and popped when done pulses.

module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       c_out;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       ready1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int compare_count  = 0;
    int mismatch_count = 0;

    logic [8:0] exp_q[$];
    logic [8:0] exp_item;
    logic [8:0] last_result;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .c_in  (cin1),
        .ready (ready1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .c_out (cout1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called at a negedge; start is held across exactly one rising edge.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        checkOutput("ready_at_start", {31'b0, ready}, 1);
        start = 1'b1;
        a     = av;
        b     = bv;
        c_in  = cv;
        exp_q.push_back({1'b0, av} + {1'b0, bv} + {8'b0, cv});
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        c_in  = 1'($urandom);
    endtask

    // Eight busy cycles with held outputs, then the done cycle.
    task automatic runAndCheck(input int inject_at);
        int bad_busy;
        int bad_hold;
        bad_busy = 0;
        bad_hold = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) bad_busy++;
            if ({c_out, sum} !== last_result) bad_hold++;
            if (i == inject_at) begin
                start = 1'b1;
                a     = 8'h11;
                b     = 8'h11;
                c_in  = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("busy_window", bad_busy, 0);
        checkOutput("held_output", bad_hold, 0);
        @(negedge clk);
        checkOutput("done_pulse", {30'b0, busy, done}, 2'b01);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                exp_item = exp_q.pop_front();
                checkOutput("result", {23'b0, c_out, sum}, {23'b0, exp_item});
                last_result = exp_item;
            end
        end
    end

    initial begin
        int seen;
        start       = 1'b0;
        a           = '0;
        b           = '0;
        c_in        = 1'b0;
        start1      = 1'b0;
        a1          = '0;
        b1          = '0;
        cin1        = 1'b0;
        last_result = '0;
        rst_n       = 1'b0;
        #2;
        checkOutput("reset_outputs", {21'b0, busy, done, c_out, sum}, 0);
        checkOutput("reset_ready", {31'b0, ready}, 1);
        checkOutput("reset_w1", {27'b0, ready1, busy1, done1, cout1, sum1}, 5'b10000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(8'h5A, 8'h3C, 1'b0);
        runAndCheck(0);
        @(negedge clk);
        checkOutput("done_single", {31'b0, done}, 0);

        applyStimulus(8'hFF, 8'h01, 1'b0);
        runAndCheck(0);
        @(negedge clk);
        checkOutput("done_single", {31'b0, done}, 0);

        applyStimulus(8'hFF, 8'h00, 1'b1);
        runAndCheck(0);
        @(negedge clk);
        checkOutput("done_single", {31'b0, done}, 0);

        applyStimulus(8'h00, 8'h00, 1'b0);
        runAndCheck(0);
        @(negedge clk);
        checkOutput("done_single", {31'b0, done}, 0);

        // Start while busy must be ignored.
        applyStimulus(8'h5A, 8'h3C, 1'b0);
        runAndCheck(3);
        @(negedge clk);
        checkOutput("done_single", {31'b0, done}, 0);

        // Back-to-back start in the done cycle.
        applyStimulus(8'h01, 8'h01, 1'b0);
        runAndCheck(0);
        applyStimulus(8'h80, 8'h80, 1'b0);
        runAndCheck(0);
        @(negedge clk);
        checkOutput("done_single", {31'b0, done}, 0);

        for (int n = 0; n < 4; n++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom));
            runAndCheck(0);
            @(negedge clk);
            checkOutput("done_single", {31'b0, done}, 0);
        end

        // Abort mid-operation with reset.
        applyStimulus(8'h33, 8'h44, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_outputs", {21'b0, busy, done, c_out, sum}, 0);
        exp_q.delete();
        last_result = '0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) seen++;
        end
        checkOutput("no_done_in_reset", seen, 0);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(8'h0F, 8'h01, 1'b0);
        runAndCheck(0);
        @(negedge clk);
        checkOutput("done_single", {31'b0, done}, 0);

        // WIDTH=1 instance: 1+1+1 -> sum=1, c_out=1.
        start1 = 1'b1;
        a1     = 1'b1;
        b1     = 1'b1;
        cin1   = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        @(negedge clk);
        checkOutput("w1_busy", {30'b0, busy1, done1}, 2'b10);
        @(negedge clk);
        checkOutput("w1_done", {28'b0, busy1, done1, cout1, sum1}, 4'b0111);
        @(negedge clk);
        checkOutput("w1_done_single", {31'b0, done1}, 0);

        checkOutput("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end
endmodule
